// File: rtl/cam_link_pkg.sv
// Shared definitions for the 11-bit parallel camera-location link.
// The receiver imports the same package so both ends agree on word packing.
package cam_link_pkg;

    localparam int WORD_W      = 11;
    localparam int FRAME_WORDS = 3;
    localparam int PAYLOAD_W   = 30;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        GAP
    } link_state_t;

    // Word k of a frame: two full 11-bit slices, then the top byte with even parity at bit 8
    function automatic logic [WORD_W-1:0] pack_word(input logic [PAYLOAD_W-1:0] payload,
                                                    input logic [1:0]           k);
        logic [WORD_W-1:0] word;
        case (k)
            2'd0:    word = payload[10:0];
            2'd1:    word = payload[21:11];
            default: word = {2'b00, ^payload, payload[29:22]};
        endcase
        return word;
    endfunction

endpackage

// File: rtl/cam_link_tx.sv
// Transmit side of the camera-location link: one payload becomes three strobed
// words framed by a lock signal, followed by an idle gap before the next frame.
module cam_link_tx
    import cam_link_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [PAYLOAD_W-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic [WORD_W-1:0]    data_out,
    output logic                 link_clk_out,
    output logic                 link_lock_out,
    output logic                 frame_done_out
);

    localparam int                 MAX_DUR   = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int                 CNT_W     = $clog2(MAX_DUR) + 1;
    localparam logic [CNT_W-1:0]   DIV_LOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [1:0]         LAST_WORD = 2'(FRAME_WORDS - 1);

    link_state_t            r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [1:0]             r_wordIdx;
    logic [PAYLOAD_W-1:0]   r_payload;
    logic [WORD_W-1:0]      r_data;
    logic                   r_clk;
    logic                   r_lock;
    logic                   r_done;

    link_state_t            w_nextState;
    logic [CNT_W-1:0]       w_nextCnt;
    logic [1:0]             w_nextWordIdx;
    logic [PAYLOAD_W-1:0]   w_nextPayload;
    logic [WORD_W-1:0]      w_nextData;
    logic                   w_nextClk;
    logic                   w_nextLock;
    logic                   w_nextDone;

    assign ready_out      = (r_state == IDLE);
    assign data_out       = r_data;
    assign link_clk_out   = r_clk;
    assign link_lock_out  = r_lock;
    assign frame_done_out = r_done;

    // Next-state logic; the phase counter reloads on each state change and counts down to zero,
    // and the output registers are derived from the state being entered so they never lag a cycle
    always_comb begin
        w_nextState   = r_state;
        w_nextCnt     = r_cnt;
        w_nextWordIdx = r_wordIdx;
        w_nextPayload = r_payload;
        case (r_state)
            IDLE: begin
                if (valid_in) begin
                    w_nextState   = LOW;
                    w_nextCnt     = DIV_LOAD;
                    w_nextWordIdx = 2'd0;
                    w_nextPayload = data_in;
                end
            end
            LOW: begin
                if (r_cnt == '0) begin
                    w_nextState = HIGH;
                    w_nextCnt   = DIV_LOAD;
                end else begin
                    w_nextCnt = r_cnt - CNT_W'(1);
                end
            end
            HIGH: begin
                if (r_cnt == '0) begin
                    if (r_wordIdx == LAST_WORD) begin
                        w_nextState = GAP;
                        w_nextCnt   = GAP_LOAD;
                    end else begin
                        w_nextState   = LOW;
                        w_nextCnt     = DIV_LOAD;
                        w_nextWordIdx = r_wordIdx + 2'd1;
                    end
                end else begin
                    w_nextCnt = r_cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    w_nextState = IDLE;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = '0;
            end
        endcase

        w_nextLock = (w_nextState == LOW) || (w_nextState == HIGH);
        w_nextClk  = (w_nextState == HIGH);
        w_nextData = w_nextLock ? pack_word(w_nextPayload, w_nextWordIdx) : '0;
        w_nextDone = (w_nextState == GAP) && (r_state != GAP);
    end

    // State, counter, latched payload and all link outputs; reset abandons any frame in flight
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wordIdx <= 2'd0;
            r_payload <= '0;
            r_data    <= '0;
            r_clk     <= 1'b0;
            r_lock    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_cnt     <= w_nextCnt;
            r_wordIdx <= w_nextWordIdx;
            r_payload <= w_nextPayload;
            r_data    <= w_nextData;
            r_clk     <= w_nextClk;
            r_lock    <= w_nextLock;
            r_done    <= w_nextDone;
        end
    end

endmodule

// File: tb/tb_cam_link_tx.sv
// Self-checking bench for cam_link_tx: a timeline model of the frame, a receiver
// that unpacks the strobed words, directed frames and a long random run.
module tb_cam_link_tx;

    localparam int D1 = 2;
    localparam int G1 = 4;
    localparam logic [29:0] P1 = 30'b000101101000001100000110000001;
    localparam logic [29:0] PONES = 30'h3FFFFFFF;

    typedef struct packed {
        logic [10:0] data;
        logic        clk;
        logic        lock;
        logic        done;
        logic        ready;
    } linkOut_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [29:0] dataIn = '0;
    logic        validIn = 1'b0;
    logic        readyOut;
    logic [10:0] dataOut;
    logic        linkClk;
    logic        linkLock;
    logic        frameDone;

    logic [29:0] dataIn2 = '0;
    logic        validIn2 = 1'b0;
    logic        readyOut2;
    logic [10:0] dataOut2;
    logic        linkClk2;
    logic        linkLock2;
    logic        frameDone2;

    int checks = 0;
    int errors = 0;

    bit          mBusy = 0;
    int          mT = 0;
    logic [29:0] mPayload = '0;
    int          mAccepted = 0;
    logic [29:0] sentQ[$];

    logic [10:0] rxWords[3];
    int          rxCnt = 0;
    int          rxFrames = 0;
    logic        prevLinkClk = 1'b0;
    logic        prevLinkLock = 1'b0;

    cam_link_tx #(.CLK_DIV(D1), .GAP_CYCLES(G1)) dut (
        .clk_in(clk), .rst_in(rst), .data_in(dataIn), .valid_in(validIn),
        .ready_out(readyOut), .data_out(dataOut), .link_clk_out(linkClk),
        .link_lock_out(linkLock), .frame_done_out(frameDone)
    );

    cam_link_tx #(.CLK_DIV(1), .GAP_CYCLES(G1)) dutDiv1 (
        .clk_in(clk), .rst_in(rst), .data_in(dataIn2), .valid_in(validIn2),
        .ready_out(readyOut2), .data_out(dataOut2), .link_clk_out(linkClk2),
        .link_lock_out(linkLock2), .frame_done_out(frameDone2)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    // Word k of a payload, built from plain shifts and a bit count
    function automatic logic [10:0] refWord(input logic [29:0] p, input int k);
        if (k == 0) return 11'(p & 30'h7FF);
        if (k == 1) return 11'((p >> 11) & 30'h7FF);
        return 11'((32'(p) >> 22) | (32'($countones(p) % 2) << 8));
    endfunction

    // Outputs t cycles after an accept edge: 3 words of 2*d cycles (strobe high in the second half), then the gap
    function automatic linkOut_t modelOut(input bit busy, input int t, input logic [29:0] p, input int d);
        linkOut_t o;
        o = '0;
        o.ready = !busy;
        if (busy && t < 6 * d) begin
            o.lock = 1'b1;
            o.clk  = (t % (2 * d)) >= d;
            o.data = refWord(p, t / (2 * d));
        end else if (busy) begin
            o.done = (t == 6 * d);
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Timeline model: accept when idle and valid, busy for 6*D+G cycles, reset abandons the frame
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            if (mBusy && mT < 6 * D1) begin
                void'(sentQ.pop_back());
                mAccepted--;
            end
            mBusy = 0;
            mT = 0;
        end else if (mBusy) begin
            if (mT == 6 * D1 + G1 - 1) mBusy = 0;
            else mT++;
        end else if (validIn) begin
            mBusy = 1;
            mT = 0;
            mPayload = dataIn;
            sentQ.push_back(dataIn);
            mAccepted++;
        end
    end

    // Compare every DUT output against the model on the falling edge
    always @(negedge clk) begin
        linkOut_t e;
        e = modelOut(mBusy, mT, mPayload, D1);
        checkOutput("data_out", 32'(dataOut), 32'(e.data));
        checkOutput("link_clk_out", 32'(linkClk), 32'(e.clk));
        checkOutput("link_lock_out", 32'(linkLock), 32'(e.lock));
        checkOutput("frame_done_out", 32'(frameDone), 32'(e.done));
        checkOutput("ready_out", 32'(readyOut), 32'(e.ready));
        checkOutput("lock with ready", 32'(linkLock & readyOut), 32'd0);
    end

    // Receiver: capture on strobe rise, unpack and parity-check on lock fall, discard partial frames
    always @(negedge clk) begin
        logic [29:0] rec;
        logic [29:0] sent;
        if (linkLock && linkClk && !prevLinkClk) begin
            if (rxCnt < 3) rxWords[rxCnt] = dataOut;
            rxCnt++;
        end
        if (!linkLock && prevLinkLock) begin
            if (rxCnt == 3) begin
                rec = {rxWords[2][7:0], rxWords[1], rxWords[0]};
                checkOutput("rx parity", 32'(rxWords[2][8]), 32'(^rec));
                checkOutput("rx pad bits", 32'(rxWords[2][10:9]), 32'd0);
                sent = (sentQ.size() > 0) ? sentQ.pop_front() : ~rec;
                checkOutput("rx payload", 32'(rec), 32'(sent));
                rxFrames++;
            end
            rxCnt = 0;
        end
        prevLinkClk = linkClk;
        prevLinkLock = linkLock;
    end

    // Offer one payload for a single cycle; returns on the falling edge after the accept edge
    task automatic applyStimulus(input logic [29:0] payload);
        @(negedge clk);
        dataIn = payload;
        validIn = 1'b1;
        @(negedge clk);
        validIn = 1'b0;
    endtask

    initial begin
        int cyc;
        int target;
        linkOut_t e;

        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("reset lock", 32'(linkLock), 32'd0);
        checkOutput("reset data", 32'(dataOut), 32'd0);
        checkOutput("reset ready", 32'(readyOut), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        checkOutput("model pin w0", 32'(modelOut(1, 0, P1, D1).data), 32'h181);
        checkOutput("model pin w2", 32'(modelOut(1, 9, P1, D1).data), 32'h116);
        checkOutput("model pin ones w2", 32'(modelOut(1, 8, PONES, D1).data), 32'h0FF);
        checkOutput("model pin done", 32'(modelOut(1, 12, P1, D1).done), 32'd1);

        // Directed frame with literal timeline expectations
        applyStimulus(P1);
        for (int t = 0; t <= 16; t++) begin
            case (t)
                0:  begin checkOutput("f1 data t0", 32'(dataOut), 32'h181);
                          checkOutput("f1 lock t0", 32'(linkLock), 32'd1);
                          checkOutput("f1 ready t0", 32'(readyOut), 32'd0); end
                2:  checkOutput("f1 clk t2", 32'(linkClk), 32'd1);
                4:  begin checkOutput("f1 data t4", 32'(dataOut), 32'h418);
                          checkOutput("f1 clk t4", 32'(linkClk), 32'd0); end
                7:  checkOutput("f1 clk t7", 32'(linkClk), 32'd1);
                8:  checkOutput("f1 data t8", 32'(dataOut), 32'h116);
                11: checkOutput("f1 lock t11", 32'(linkLock), 32'd1);
                12: begin checkOutput("f1 done t12", 32'(frameDone), 32'd1);
                          checkOutput("f1 lock t12", 32'(linkLock), 32'd0); end
                13: checkOutput("f1 done t13", 32'(frameDone), 32'd0);
                15: checkOutput("f1 ready t15", 32'(readyOut), 32'd0);
                16: checkOutput("f1 ready t16", 32'(readyOut), 32'd1);
                default: ;
            endcase
            @(negedge clk);
        end

        // Valid held from mid-frame: ignored until idle, then the all-ones payload follows back to back
        applyStimulus(P1);
        for (int t = 1; t <= 34; t++) begin
            @(negedge clk);
            if (t == 4) begin
                dataIn = PONES;
                validIn = 1'b1;
            end
            if (t == 16) begin
                checkOutput("b2b ready t16", 32'(readyOut), 32'd1);
                checkOutput("b2b lock t16", 32'(linkLock), 32'd0);
            end
            if (t == 17) begin
                validIn = 1'b0;
                checkOutput("b2b lock t17", 32'(linkLock), 32'd1);
                checkOutput("b2b data t17", 32'(dataOut), 32'h7FF);
            end
            if (t == 21) checkOutput("ones w1", 32'(dataOut), 32'h7FF);
            if (t == 25) checkOutput("ones w2", 32'(dataOut), 32'h0FF);
        end

        // Reset in the middle of word 1
        applyStimulus(P1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset lock", 32'(linkLock), 32'd0);
        checkOutput("midreset clk", 32'(linkClk), 32'd0);
        checkOutput("midreset data", 32'(dataOut), 32'd0);
        checkOutput("midreset ready", 32'(readyOut), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(30'h2A5A_1234);
        repeat (20) @(negedge clk);

        // Strobe divider of one on the second instance
        @(negedge clk);
        dataIn2 = PONES;
        validIn2 = 1'b1;
        @(negedge clk);
        validIn2 = 1'b0;
        for (int t = 0; t <= 10; t++) begin
            e = modelOut(1, t, PONES, 1);
            checkOutput("div1 clk", 32'(linkClk2), 32'(e.clk));
            checkOutput("div1 data", 32'(dataOut2), 32'(e.data));
            checkOutput("div1 lock", 32'(linkLock2), 32'(e.lock));
            checkOutput("div1 done", 32'(frameDone2), 32'(e.done));
            if (t == 1 || t == 3 || t == 5) checkOutput("div1 strobe high", 32'(linkClk2), 32'd1);
            if (t == 4) checkOutput("div1 w2", 32'(dataOut2), 32'h0FF);
            @(negedge clk);
        end

        // Random payloads with random valid, until 1000 more frames have been accepted
        target = mAccepted + 1000;
        cyc = 0;
        while (mAccepted < target && cyc < 25000) begin
            dataIn = 30'($urandom);
            validIn = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            cyc++;
        end
        validIn = 1'b0;
        checkOutput("random frames accepted in budget", 32'(mAccepted >= target), 32'd1);
        repeat (20) @(negedge clk);

        checkOutput("rx frame count", 32'(rxFrames), 32'(mAccepted));
        checkOutput("rx queue drained", 32'(sentQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
